// File: rtl/decoder_pkg.sv
// decoder_pkg: mode and state enums plus dwell counter width shared by the scan decoder
package decoder_pkg;
  localparam int DWELL_W = 16;
  typedef enum logic [1:0] {DEC_OFF, DEC_DIRECT, DEC_SCAN, DEC_SWEEP} dec_mode_t;
  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN, S_SWEEP} dec_state_t;
endpackage

// File: rtl/decoder_onehot_param.sv
// decoder_onehot_param: combinational N-to-2^N one-hot decode; en gates output, sel picks the hot bit, y is the result
module decoder_onehot_param #(
  parameter int N = 4
) (
  input  logic              en,
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] y
);
  always_comb begin
    y = '0;
    y[sel] = en;
  end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: registered one-hot decoder with direct/scan/sweep sequencing; clk/rst(async low) control, ena/mode/in/start in, out/index/busy/done registered out
module decoder_scan_sequencer
  import decoder_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      in,
  input  logic              start,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      index,
  output logic              busy,
  output logic              done
);
  localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);
  localparam logic [N-1:0] LAST = '1;
  dec_state_t state, state_n;
  dec_mode_t mode_e;
  logic [DWELL_W-1:0] cnt, cnt_n, adv_cnt;
  logic [N-1:0] idx_n, adv_idx;
  logic [(1<<N)-1:0] dec;
  logic en_n, done_n, wrap;
  assign mode_e = dec_mode_t'(mode);
  assign wrap = cnt == '0;
  assign adv_cnt = ena ? (wrap ? RELOAD : cnt - 1'b1) : cnt;
  assign adv_idx = ena && wrap ? index + 1'b1 : index;
  always_comb begin
    state_n = S_IDLE;
    idx_n = index;
    cnt_n = cnt;
    en_n = 1'b0;
    done_n = 1'b0;
    case (mode_e)
      DEC_DIRECT: begin
        state_n = S_DIRECT;
        idx_n = in;
        en_n = ena;
      end
      DEC_SCAN: begin
        state_n = S_SCAN;
        en_n = ena;
        idx_n = state == S_SCAN ? adv_idx : '0;
        cnt_n = state == S_SCAN ? adv_cnt : RELOAD;
      end
      DEC_SWEEP:
        if (state == S_SWEEP) begin
          if (ena && wrap && index == LAST)
            done_n = 1'b1;
          else begin
            state_n = S_SWEEP;
            en_n = ena;
            idx_n = adv_idx;
            cnt_n = adv_cnt;
          end
        end else if (start) begin
          state_n = S_SWEEP;
          en_n = ena;
          idx_n = '0;
          cnt_n = RELOAD;
        end
      default: ;
    endcase
  end
  decoder_onehot_param #(.N(N)) u_dec (
    .en  (en_n),
    .sel (idx_n),
    .y   (dec)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      index <= '0;
      out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      index <= idx_n;
      out <= dec;
      busy <= state_n == S_SWEEP;
      done <= done_n;
    end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed plus random stimulus on DWELL=1 and DWELL=3 instances against a position-count reference model
module tb_decoder_scan_sequencer;
  localparam int K_NONE = 0, K_DIRECT = 1, K_SCAN = 2, K_SWEEP = 3;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] in = 4'd0;
  logic [15:0] out1, out3;
  logic [3:0] index1, index3;
  logic busy1, busy3, done1, done3;
  int checks = 0, errors = 0, ndone = 0;
  int dw[2] = '{1, 3};
  int m_kind[2], m_pos[2], m_idx[2], m_out[2], m_busy[2], m_done[2];

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.N(4), .DWELL(1)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in(in), .start(start),
    .out(out1), .index(index1), .busy(busy1), .done(done1)
  );
  decoder_scan_sequencer #(.N(4), .DWELL(3)) u3 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in(in), .start(start),
    .out(out3), .index(index3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = K_NONE; m_pos[i] = 0; m_idx[i] = 0;
      m_out[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  // Sequencer position = enabled edges since entry; shown index = position / dwell.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int span;
      span = 16 * dw[i];
      m_done[i] = 0;
      case (mode)
        2'd1: begin
          m_kind[i] = K_DIRECT;
          m_idx[i] = int'(in);
          m_out[i] = ena ? (1 << m_idx[i]) : 0;
        end
        2'd2: begin
          if (m_kind[i] != K_SCAN) begin
            m_kind[i] = K_SCAN;
            m_pos[i] = 0;
          end else if (ena) m_pos[i] = (m_pos[i] + 1) % span;
          m_idx[i] = m_pos[i] / dw[i];
          m_out[i] = ena ? (1 << m_idx[i]) : 0;
        end
        2'd3: begin
          if (m_kind[i] == K_SWEEP) begin
            if (ena) begin
              m_pos[i]++;
              if (m_pos[i] == span) begin
                m_kind[i] = K_NONE;
                m_out[i] = 0;
                m_done[i] = 1;
              end else begin
                m_idx[i] = m_pos[i] / dw[i];
                m_out[i] = 1 << m_idx[i];
              end
            end else m_out[i] = 0;
          end else if (start) begin
            m_kind[i] = K_SWEEP;
            m_pos[i] = 0;
            m_idx[i] = 0;
            m_out[i] = ena ? 1 : 0;
          end else begin
            m_kind[i] = K_NONE;
            m_out[i] = 0;
          end
        end
        default: begin
          m_kind[i] = K_NONE;
          m_out[i] = 0;
        end
      endcase
      m_busy[i] = (m_kind[i] == K_SWEEP) ? 1 : 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out1"}, 32'(out1), m_out[0]);
    chk({tag, ".idx1"}, 32'(index1), m_idx[0]);
    chk({tag, ".busy1"}, 32'(busy1), m_busy[0]);
    chk({tag, ".done1"}, 32'(done1), m_done[0]);
    chk({tag, ".out3"}, 32'(out3), m_out[1]);
    chk({tag, ".idx3"}, 32'(index3), m_idx[1]);
    chk({tag, ".busy3"}, 32'(busy3), m_busy[1]);
    chk({tag, ".done3"}, 32'(done3), m_done[1]);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    ndone += int'(done1);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1 check_all("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    mode = 2'd1; ena = 1'b1; in = 4'hA;
    tick("direct_a");
    chk("direct_a_out", 32'(out1), 32'h0400);
    ena = 1'b0;
    tick("direct_off");
    chk("direct_off_out", 32'(out1), 32'h0);
    repeat (12) begin
      in = 4'($urandom);
      ena = ($urandom_range(3, 0) != 0);
      tick("direct_rand");
    end

    mode = 2'd2; ena = 1'b1;
    repeat (60) tick("scan");
    repeat (40) begin
      ena = ($urandom_range(3, 0) != 0);
      tick("scan_ena");
    end

    mode = 2'd0; ena = 1'b1;
    tick("off");
    mode = 2'd3; start = 1'b1;
    tick("sweep_go");
    start = 1'b0;
    repeat (55) tick("sweep");

    start = 1'b1;
    tick("sweep2_go");
    start = 1'b0;
    repeat (5) tick("sweep2");
    chk("pause_idx_pre", 32'(index1), 32'd5);
    ndone = 0;
    ena = 1'b0;
    repeat (4) tick("pause");
    chk("pause_idx", 32'(index1), 32'd5);
    chk("pause_out", 32'(out1), 32'h0);
    chk("pause_busy", 32'(busy1), 32'd1);
    ena = 1'b1;
    tick("resume");
    repeat (48) tick("resume_run");
    chk("pause_done_cnt", 32'(ndone), 32'd1);

    start = 1'b1;
    tick("sweep3_go");
    start = 1'b0;
    repeat (7) tick("sweep3");
    chk("abort_idx_pre", 32'(index1), 32'd7);
    ndone = 0;
    mode = 2'd1; in = 4'd2; start = 1'b1;
    tick("abort");
    chk("abort_out", 32'(out1), 32'h0004);
    chk("abort_busy", 32'(busy1), 32'd0);
    repeat (5) tick("abort_hold");
    chk("abort_done_cnt", 32'(ndone), 32'd0);

    mode = 2'd3; start = 1'b1;
    repeat (60) tick("start_held");
    start = 1'b0;

    repeat (400) begin
      mode = 2'($urandom_range(3, 0));
      ena = ($urandom_range(7, 0) != 0);
      start = ($urandom_range(3, 0) == 0);
      in = 4'($urandom);
      tick("random");
    end

    mode = 2'd2; ena = 1'b1; start = 1'b0;
    repeat (6) tick("prerst_scan");
    #2 rst = 1'b0;
    #1;
    chk("arst_out1", 32'(out1), 32'h0);
    chk("arst_idx1", 32'(index1), 32'd0);
    chk("arst_out3", 32'(out3), 32'h0);
    chk("arst_idx3", 32'(index3), 32'd0);
    chk("arst_busy1", 32'(busy1), 32'd0);
    chk("arst_done1", 32'(done1), 32'd0);
    model_reset();
    @(posedge clk);
    #1 check_all("in_reset");
    rst = 1'b1;
    tick("post_rst");
    chk("post_rst_out3", 32'(out3), 32'h0001);
    repeat (8) tick("post_rst_scan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a built-in sequencer.
- Three active modes: direct decode of an input index, continuous scan that walks the one-hot output with a programmable dwell, and a single sweep with a completion pulse.
- Drives row/column selects, mux enables and register-file write strobes in the lab datapath.
- Supersedes the fixed-width combinational decoders for any consumer that needs timed or registered selects.

Parameters:
- N, 4: select width; output width is 2^N.
- DWELL, 1: cycles each index is held in SCAN/SWEEP; legal range is 1 to 2^16-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; low forces out to 0 and freezes the sequencer.
- mode  in  2  0=OFF, 1=DIRECT, 2=SCAN, 3=SWEEP.
- in  in  N  index for DIRECT mode.
- start  in  1  single-cycle request to begin a SWEEP.
- out  out  2^N  registered one-hot output, or all-zero.
- index  out  N  index currently asserted or last asserted.
- busy  out  1  high while a SWEEP is in progress.
- done  out  1  one-cycle pulse after the final SWEEP step.

Behaviour:
- Reset (rst=0, asynchronous): out=0, index=0, busy=0, done=0, dwell counter=0, state=S_IDLE.
- All outputs are registered. Inputs sampled on edge k are visible after edge k.
- States: S_IDLE, S_DIRECT, S_SCAN, S_SWEEP.
  - mode=0 leads to S_IDLE.
  - mode=1 leads to S_DIRECT.
  - mode=2 leads to S_SCAN.
  - mode=3 stays in S_IDLE until start, then S_SWEEP.
- Mode changes take effect on the next edge. Leaving S_SWEEP early aborts it: busy clears and done is not pulsed.
- S_IDLE: out=0. index holds its value.
- S_DIRECT: out = 1<<in when ena=1, otherwise 0. index=in. Latency is one cycle; a new value of in is accepted every cycle.
- S_SCAN:
  - On entry: index=0, out=1<<0, dwell counter=DWELL-1.
  - Each enabled cycle the counter decrements. At 0 the counter reloads and index increments, wrapping from 2^N-1 to 0.
  - DWELL=1 means index steps every cycle.
- S_SWEEP:
  - Entry on start=1 while mode=3 and not busy: busy=1, index=0, out=1<<0.
  - Steps exactly as in S_SCAN, but after index 2^N-1 has been held for DWELL cycles it does not wrap. Instead, on the same edge: out=0, busy=0, done=1 for one cycle, then back to S_IDLE.
  - A full sweep holds out nonzero for 2^N*DWELL enabled cycles.
  - start while busy=1 is ignored.
  - start in the same cycle that done is asserted begins a new sweep on the following edge.
- ena=0 in S_SCAN or S_SWEEP: out=0, dwell counter and index frozen, busy unchanged. When ena returns to 1, out is restored to 1<<index with the remaining dwell.
- Widths:
  - Dwell counter is 16 bits.
  - index wrap is natural N-bit overflow.
  - out is never more than one-hot.
- rst asserted mid-sweep returns everything to the reset values immediately; done is not pulsed.

Decomposition:
- Shared package decoder_pkg:
  - typedef enum logic [1:0] dec_mode_t {DEC_OFF, DEC_DIRECT, DEC_SCAN, DEC_SWEEP}.
  - State enum.
  - Localparam DWELL_W = 16.
- Sub-module decoder_onehot_param: combinational N-to-2^N decode with enable. Instantiated once, driven by the muxed index. The top level registers its output.

Test Plan:
- Reset then mode=1, ena=1, in=4'hA (N=4) -> one cycle later out=16'h0400, index=A. Set ena=0 -> next cycle out=0.
- mode=2, DWELL=3 -> out sequence 0x0001 for 3 cycles, 0x0002 for 3 cycles, and so on up to 0x8000, then wraps to 0x0001.
- mode=3, DWELL=1, start pulsed -> busy=1 for 16 cycles, out steps 0x0001 through 0x8000, then out=0, busy=0, done=1 for exactly one cycle.
- Sweep at index 5 with ena=0 for 4 cycles -> out=0 and index=5 held; after ena returns, 0x0020 completes its remaining dwell and the sweep finishes normally with done pulsed once.
- Sweep at index 7 with mode switched to 1, in=2 -> next cycle out=0x0004, busy=0, done never asserts. start during busy -> ignored, with no restart.
- rst dropped asynchronously mid-scan (between edges) -> out, index, busy and done go to 0 immediately. After release with mode=2 -> scan restarts at index 0.
